collector_29_to_1_7bits: RTL and testbench

COLLECTOR_29_TO_1_7BITS -- requirements
Module: collector_29_to_1_7bits

---
 rtl/collector_29_to_1_7bits_pkg.sv | 19 +
 rtl/collector_29_to_1_7bits_mux.sv | 55 +++++
 rtl/collector_29_to_1_7bits.sv | 105 ++++++++++
 tb/tb_collector_29_to_1_7bits.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/collector_29_to_1_7bits_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | collector_29_to_1_7bits_pkg : shared sizes and FSM encoding      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package collector_29_to_1_7bits_pkg;

  localparam int DATA_WIDTH = 7;
  localparam int CHANNELS   = 29;
  localparam int SEL_WIDTH  = 5;

  localparam logic [SEL_WIDTH-1:0] SEL_FIRST = 5'd1;
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = 5'd29;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

endpackage
`default_nettype wire

// File: rtl/collector_29_to_1_7bits_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_29_to_1_7bits : combinational 29-way word select, 0 if no    |
// | valid channel is selected. rev 1.0                               |
// +------------------------------------------------------------------+
module mux_29_to_1_7bits
  import collector_29_to_1_7bits_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] din_1,  din_2,  din_3,  din_4,  din_5,  din_6,
  input  logic [DATA_WIDTH-1:0] din_7,  din_8,  din_9,  din_10, din_11, din_12,
  input  logic [DATA_WIDTH-1:0] din_13, din_14, din_15, din_16, din_17, din_18,
  input  logic [DATA_WIDTH-1:0] din_19, din_20, din_21, din_22, din_23, din_24,
  input  logic [DATA_WIDTH-1:0] din_25, din_26, din_27, din_28, din_29,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    case (sel)
      5'd1:  dout = din_1;
      5'd2:  dout = din_2;
      5'd3:  dout = din_3;
      5'd4:  dout = din_4;
      5'd5:  dout = din_5;
      5'd6:  dout = din_6;
      5'd7:  dout = din_7;
      5'd8:  dout = din_8;
      5'd9:  dout = din_9;
      5'd10: dout = din_10;
      5'd11: dout = din_11;
      5'd12: dout = din_12;
      5'd13: dout = din_13;
      5'd14: dout = din_14;
      5'd15: dout = din_15;
      5'd16: dout = din_16;
      5'd17: dout = din_17;
      5'd18: dout = din_18;
      5'd19: dout = din_19;
      5'd20: dout = din_20;
      5'd21: dout = din_21;
      5'd22: dout = din_22;
      5'd23: dout = din_23;
      5'd24: dout = din_24;
      5'd25: dout = din_25;
      5'd26: dout = din_26;
      5'd27: dout = din_27;
      5'd28: dout = din_28;
      5'd29: dout = din_29;
      default: dout = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/collector_29_to_1_7bits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | collector_29_to_1_7bits : captures 29 words on load and streams  |
// | them out one per accepted handshake. rev 1.0                     |
// +------------------------------------------------------------------+
module collector_29_to_1_7bits
  import collector_29_to_1_7bits_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int CHANNELS   = 29
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_1,  din_2,  din_3,  din_4,  din_5,  din_6,
  input  logic [DATA_WIDTH-1:0] din_7,  din_8,  din_9,  din_10, din_11, din_12,
  input  logic [DATA_WIDTH-1:0] din_13, din_14, din_15, din_16, din_17, din_18,
  input  logic [DATA_WIDTH-1:0] din_19, din_20, din_21, din_22, din_23, din_24,
  input  logic [DATA_WIDTH-1:0] din_25, din_26, din_27, din_28, din_29,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  busy,
  output logic                  done
);

  logic [0:0]            r_state;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_bank [1:CHANNELS];
  logic [DATA_WIDTH-1:0] w_din  [1:CHANNELS];
  logic                  w_capture;

  assign w_din = '{din_1,  din_2,  din_3,  din_4,  din_5,  din_6,  din_7,
                   din_8,  din_9,  din_10, din_11, din_12, din_13, din_14,
                   din_15, din_16, din_17, din_18, din_19, din_20, din_21,
                   din_22, din_23, din_24, din_25, din_26, din_27, din_28,
                   din_29};

  assign w_capture = !reset && (r_state == IDLE) && load;

  // Bank has no reset; it is only visible through sel, which is 0 until a load.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_bank <= w_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_state <= SEND;
            r_sel   <= SEL_FIRST;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (r_sel == SEL_LAST) begin
              r_state <= IDLE;
              r_sel   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= '0;
        end
      endcase
    end
  end

  // Outputs derive only from registered state, so dout_ready never reaches them.
  assign busy       = (r_state == SEND);
  assign dout_valid = busy;
  assign sel        = r_sel;
  assign done       = r_done;

  mux_29_to_1_7bits u_mux (
    .din_1 (r_bank[1]),  .din_2 (r_bank[2]),  .din_3 (r_bank[3]),
    .din_4 (r_bank[4]),  .din_5 (r_bank[5]),  .din_6 (r_bank[6]),
    .din_7 (r_bank[7]),  .din_8 (r_bank[8]),  .din_9 (r_bank[9]),
    .din_10(r_bank[10]), .din_11(r_bank[11]), .din_12(r_bank[12]),
    .din_13(r_bank[13]), .din_14(r_bank[14]), .din_15(r_bank[15]),
    .din_16(r_bank[16]), .din_17(r_bank[17]), .din_18(r_bank[18]),
    .din_19(r_bank[19]), .din_20(r_bank[20]), .din_21(r_bank[21]),
    .din_22(r_bank[22]), .din_23(r_bank[23]), .din_24(r_bank[24]),
    .din_25(r_bank[25]), .din_26(r_bank[26]), .din_27(r_bank[27]),
    .din_28(r_bank[28]), .din_29(r_bank[29]),
    .sel   (r_sel),
    .dout  (dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_collector_29_to_1_7bits.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_collector_29_to_1_7bits : directed + random bench with a      |
// | queue-based reference model. rev 1.0                             |
// +------------------------------------------------------------------+
module tb_collector_29_to_1_7bits;

  logic       clk = 1'b0;
  logic       reset, load, dout_ready;
  logic [6:0] din [1:29];
  logic [6:0] dout;
  logic       dout_valid, busy, done;
  logic [4:0] sel;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] idx;
    logic [6:0] w;
  } ent_t;

  // Words still owed to the consumer for the frame in flight, head first.
  ent_t pending [$];
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  collector_29_to_1_7bits #(.DATA_WIDTH(7), .CHANNELS(29)) dut (
    .clk(clk), .reset(reset),
    .din_1 (din[1]),  .din_2 (din[2]),  .din_3 (din[3]),  .din_4 (din[4]),
    .din_5 (din[5]),  .din_6 (din[6]),  .din_7 (din[7]),  .din_8 (din[8]),
    .din_9 (din[9]),  .din_10(din[10]), .din_11(din[11]), .din_12(din[12]),
    .din_13(din[13]), .din_14(din[14]), .din_15(din[15]), .din_16(din[16]),
    .din_17(din[17]), .din_18(din[18]), .din_19(din[19]), .din_20(din[20]),
    .din_21(din[21]), .din_22(din[22]), .din_23(din[23]), .din_24(din[24]),
    .din_25(din[25]), .din_26(din[26]), .din_27(din[27]), .din_28(din[28]),
    .din_29(din[29]),
    .load(load), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sel(sel), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs present at this edge, clock once, compare.
  task automatic tick(input string tag);
    ent_t       e;
    logic [4:0] e_sel;
    logic [6:0] e_dout;
    if (reset) begin
      pending.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (pending.size() == 0) begin
        if (load) begin
          for (int k = 1; k <= 29; k++) begin
            e.idx = 5'(k);
            e.w   = din[k];
            pending.push_back(e);
          end
        end
      end else if (dout_ready) begin
        void'(pending.pop_front());
        if (pending.size() == 0) exp_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    e_sel  = (pending.size() != 0) ? pending[0].idx : 5'd0;
    e_dout = (pending.size() != 0) ? pending[0].w   : 7'd0;
    check({tag, ".valid"}, 32'(dout_valid), 32'(pending.size() != 0));
    check({tag, ".busy"},  32'(busy),       32'(pending.size() != 0));
    check({tag, ".sel"},   32'(sel),        32'(e_sel));
    check({tag, ".dout"},  32'(dout),       32'(e_dout));
    check({tag, ".done"},  32'(done),       32'(exp_done));
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (pending.size() != 0 && guard < 200) begin
      tick(tag);
      guard++;
    end
    check({tag, ".drain_bound"}, 32'(pending.size() == 0), 32'd1);
  endtask

  initial begin
    logic [6:0] saved [1:29];
    logic [6:0] got [$];
    logic [6:0] first;

    reset = 1'b1; load = 1'b0; dout_ready = 1'b0;
    for (int k = 1; k <= 29; k++) din[k] = 7'd0;

    // Reset state, then first load on the first reset-free edge
    tick("rst0");
    tick("rst1");
    check("rst.sel_zero", 32'(sel), 32'd0);
    check("rst.dout_zero", 32'(dout), 32'd0);

    // Incrementing pattern, ready held high: 29 words on 29 consecutive cycles
    reset = 1'b0; dout_ready = 1'b1; load = 1'b1;
    for (int k = 1; k <= 29; k++) din[k] = 7'(k);
    tick("s35_load");
    load = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      check("s35_word", 32'(dout), 32'(k));
      check("s35_sel",  32'(sel),  32'(k));
      din[k] = 7'h00;
      tick("s35");
    end
    check("s35_done_pulse", 32'(done), 32'd1);
    tick("s35_after");
    check("s35_idle_valid", 32'(dout_valid), 32'd0);
    check("s35_idle_sel",   32'(sel),        32'd0);
    check("s35_done_clear", 32'(done),       32'd0);

    // Ready toggling every cycle: order 126..98, no drops or duplicates
    for (int k = 1; k <= 29; k++) din[k] = 7'(7'h7F - k);
    load = 1'b1; dout_ready = 1'b0;
    tick("s36_load");
    load = 1'b0;
    got.delete();
    for (int c = 0; c < 200 && pending.size() != 0; c++) begin
      dout_ready = ~dout_ready;
      if (dout_valid && dout_ready) got.push_back(dout);
      tick("s36");
    end
    check("s36_count", 32'(got.size()), 32'd29);
    for (int k = 1; k <= 29 && k <= got.size(); k++)
      check("s36_word", 32'(got[k-1]), 32'(7'h7F - k));
    dout_ready = 1'b1;
    tick("s36_after");

    // Ready low for 5 cycles after load: first word held
    for (int k = 1; k <= 29; k++) din[k] = 7'($urandom);
    first = din[1];
    dout_ready = 1'b0; load = 1'b1;
    tick("s40_load");
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("s40_hold_dout", 32'(dout), 32'(first));
      check("s40_hold_sel",  32'(sel),  32'd1);
      tick("s40_stall");
    end
    dout_ready = 1'b1;
    tick("s40_rise");
    check("s40_advanced", 32'(sel), 32'd2);
    drain("s40_drain");
    tick("s40_after");

    // Load pulsed mid-frame with new data must be ignored
    for (int k = 1; k <= 29; k++) begin
      din[k]   = 7'($urandom);
      saved[k] = din[k];
    end
    load = 1'b1;
    tick("s37_load");
    load = 1'b0;
    for (int i = 0; i < 9; i++) tick("s37_run");
    check("s37_sel10", 32'(sel), 32'd10);
    check("s37_w10", 32'(dout), 32'(saved[10]));
    for (int k = 1; k <= 29; k++) din[k] = 7'h55;
    load = 1'b1;
    tick("s37_ignored");
    load = 1'b0;
    for (int k = 11; k <= 29; k++) begin
      check("s37_orig", 32'(dout), 32'(saved[k]));
      tick("s37_tail");
    end
    check("s37_done", 32'(done), 32'd1);
    tick("s37_after");

    // Reset mid-frame at sel=15, then restart with new data
    for (int k = 1; k <= 29; k++) din[k] = 7'($urandom);
    load = 1'b1;
    tick("s38_load");
    load = 1'b0;
    for (int i = 0; i < 14; i++) tick("s38_run");
    check("s38_sel15", 32'(sel), 32'd15);
    reset = 1'b1;
    tick("s38_reset");
    reset = 1'b0;
    check("s38_valid0", 32'(dout_valid), 32'd0);
    check("s38_sel0",   32'(sel),        32'd0);
    check("s38_dout0",  32'(dout),       32'd0);
    check("s38_done0",  32'(done),       32'd0);
    for (int k = 1; k <= 29; k++) din[k] = 7'($urandom);
    first = din[1];
    load = 1'b1;
    tick("s38_reload");
    load = 1'b0;
    check("s38_restart_sel",  32'(sel),  32'd1);
    check("s38_restart_dout", 32'(dout), 32'(first));
    drain("s38_drain");

    // Back-to-back: load on the done cycle, second frame 2..58
    check("s39_done_cycle", 32'(done), 32'd1);
    check("s39_gap_valid", 32'(dout_valid), 32'd0);
    for (int k = 1; k <= 29; k++) din[k] = 7'(2 * k);
    load = 1'b1;
    tick("s39_load");
    load = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      check("s39_valid", 32'(dout_valid), 32'd1);
      check("s39_word",  32'(dout),       32'(2 * k));
      tick("s39");
    end
    check("s39_done", 32'(done), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 7) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      for (int k = 1; k <= 29; k++) din[k] = 7'($urandom);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
